multi_lane_traffic_light: RTL

Parametrised N-lane intersection controller: the next generation of the single-lane traffic light. It rotates right-of-way round-robin across `NUM_LANES` approaches, with configurable green, yellow and all-red intervals counted in prescaled ticks. It skips lanes with no waiting vehicle and inserts a latched pedestrian WALK phase. It sits at the top of the traffic-light datapath and drives the lamp outputs directly.

---
 rtl/traffic_light_pkg.sv | 38 +++
 rtl/tl_tick_prescaler.sv | 23 ++
 rtl/multi_lane_traffic_light.sv | 120 ++++++++++++
 3 files changed

// File: rtl/traffic_light_pkg.sv
// Shared types, lamp encodings and round-robin lane picker for the
// multi-lane traffic-light controller.
package traffic_light_pkg;

  typedef enum logic [1:0] {
    GREEN    = 2'd0,
    YELLOW   = 2'd1,
    ALL_RED  = 2'd2,
    PED_WALK = 2'd3
  } tl_state_t;

  // Per-lane lamp word, packed as {red, yellow, green}
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  localparam int MAX_LANES  = 32;
  localparam int LANE_IDX_W = 5;

  // First occupied lane after cur in cyclic order; cur itself is the last
  // candidate. Falls back to plain rotation when no lane is occupied.
  function automatic logic [LANE_IDX_W-1:0] next_lane(
    input logic [MAX_LANES-1:0]  present,
    input logic [LANE_IDX_W-1:0] cur,
    input int unsigned           n
  );
    int unsigned j;
    j = (32'(cur) + 32'd1) % n;
    next_lane = j[LANE_IDX_W-1:0];
    for (int unsigned k = MAX_LANES; k >= 1; k--) begin
      if (k <= n) begin
        j = (32'(cur) + k) % n;
        if (present[j[LANE_IDX_W-1:0]]) next_lane = j[LANE_IDX_W-1:0];
      end
    end
  endfunction

endpackage

// File: rtl/tl_tick_prescaler.sv
// Divides clk down to a one-cycle tick strobe every TICK_DIV cycles;
// clear restarts the count so every phase begins on a fresh tick period.
module tl_tick_prescaler #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clear || tick) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/multi_lane_traffic_light.sv
// N-lane round-robin intersection controller with empty-lane skipping and a
// latched pedestrian WALK phase; lamps are decoded from registered state only.
module multi_lane_traffic_light
  import traffic_light_pkg::*;
#(
  parameter int NUM_LANES     = 4,
  parameter int TICK_DIV      = 1,
  parameter int GREEN_TICKS   = 8,
  parameter int YELLOW_TICKS  = 3,
  parameter int ALL_RED_TICKS = 2,
  parameter int PED_TICKS     = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pedstrian_button,
  input  logic [NUM_LANES-1:0]         car_present,
  output logic [NUM_LANES-1:0]         red,
  output logic [NUM_LANES-1:0]         yellow,
  output logic [NUM_LANES-1:0]         green,
  output logic                         walk,
  output logic [$clog2(NUM_LANES)-1:0] cur_lane
);

  localparam int LW      = $clog2(NUM_LANES);
  localparam int MAX_GY  = (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
  localparam int MAX_AP  = (ALL_RED_TICKS > PED_TICKS) ? ALL_RED_TICKS : PED_TICKS;
  localparam int MAX_DUR = (MAX_GY > MAX_AP) ? MAX_GY : MAX_AP;
  localparam int TW      = $clog2(MAX_DUR + 1);

  if (NUM_LANES < 2 || NUM_LANES > MAX_LANES) begin : g_bad_lanes
    $error("NUM_LANES must be in 2..%0d", MAX_LANES);
  end
  if (TICK_DIV < 1) begin : g_bad_div
    $error("TICK_DIV must be >= 1");
  end
  if (GREEN_TICKS < 1 || YELLOW_TICKS < 1 || ALL_RED_TICKS < 1 || PED_TICKS < 1) begin : g_bad_dur
    $error("all phase durations must be >= 1");
  end

  tl_state_t      state;
  logic [TW-1:0]  timer;
  logic [TW-1:0]  dur_last;
  logic           ped_pending;
  logic           tick;
  logic           phase_done;
  logic           go_walk;
  logic [LW-1:0]  lane_nxt;

  tl_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (phase_done),
    .tick  (tick)
  );

  always_comb begin
    dur_last = TW'(GREEN_TICKS - 1);
    case (state)
      GREEN:    dur_last = TW'(GREEN_TICKS - 1);
      YELLOW:   dur_last = TW'(YELLOW_TICKS - 1);
      ALL_RED:  dur_last = TW'(ALL_RED_TICKS - 1);
      PED_WALK: dur_last = TW'(PED_TICKS - 1);
      default:  dur_last = TW'(GREEN_TICKS - 1);
    endcase
  end

  assign phase_done = tick && (timer == dur_last);
  // A press in the final all-red cycle still wins this rotation
  assign go_walk    = ped_pending || pedstrian_button;
  assign lane_nxt   = LW'(next_lane(MAX_LANES'(car_present), LANE_IDX_W'(cur_lane), NUM_LANES));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= GREEN;
      cur_lane    <= '0;
      timer       <= '0;
      ped_pending <= 1'b0;
    end else begin
      if (phase_done) begin
        timer <= '0;
        case (state)
          GREEN:  state <= YELLOW;
          YELLOW: state <= ALL_RED;
          ALL_RED: begin
            if (go_walk) begin
              state <= PED_WALK;
            end else begin
              state    <= GREEN;
              cur_lane <= lane_nxt;
            end
          end
          default: begin
            state    <= GREEN;
            cur_lane <= lane_nxt;
          end
        endcase
      end else if (tick) begin
        timer <= timer + 1'b1;
      end

      if (phase_done && state == ALL_RED && go_walk) ped_pending <= 1'b0;
      else if (state != PED_WALK && pedstrian_button) ped_pending <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lamp
    logic [2:0] lamp;
    always_comb begin
      lamp = LAMP_RED;
      if (cur_lane == LW'(i)) begin
        if (state == GREEN)       lamp = LAMP_GREEN;
        else if (state == YELLOW) lamp = LAMP_YELLOW;
      end
    end
    assign {red[i], yellow[i], green[i]} = lamp;
  end

  assign walk = (state == PED_WALK);

endmodule
